// File: rtl/korev_mem_pkg.sv
// Shared types for the IF/LS memory arbiter: FSM states, owner encoding and the memory command payload.
package korev_mem_pkg;

  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_STRB_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_e;
  typedef enum logic       {OWN_IF, OWN_LS} arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_STRB_W-1:0] wstrb;
  } mem_cmd_t;

  // Owner for the next grant; with rr_en a tie goes to whoever was not served last.
  function automatic arb_owner_e pick_owner(logic if_req, logic ls_req, logic rr_en,
                                            arb_owner_e last);
    if (if_req && ls_req) begin
      return (rr_en && (last == OWN_LS)) ? OWN_IF : OWN_LS;
    end
    return ls_req ? OWN_LS : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog counter for the arbiter BUSY state; expired flags the last allowed BUSY cycle.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, clear, enable};
    assign expired   = 1'b0;
  end else begin : g_on
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS), one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed LS-over-IF priority.
module mem_arbiter
  import korev_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [MEM_ADDR_W-1:0] if_addr,
  output logic                  if_drdy,
  output logic [MEM_DATA_W-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [MEM_ADDR_W-1:0] ls_addr,
  input  logic [MEM_DATA_W-1:0] ls_wdata,
  input  logic [MEM_STRB_W-1:0] ls_wstrb,
  output logic                  ls_drdy,
  output logic [MEM_DATA_W-1:0] ls_rdata,
  output logic                  ls_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic [MEM_STRB_W-1:0] mem_wstrb,
  input  logic                  mem_drdy,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

`ifdef MEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  mem_cmd_t              cmd_q, cmd_d;
  logic                  mem_req_q, mem_req_d;
  logic                  if_drdy_q, if_drdy_d, if_err_q, if_err_d;
  logic                  ls_drdy_q, ls_drdy_d, ls_err_q, ls_err_d;
  logic [MEM_DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

  arb_owner_e            grant_c;
  logic                  timer_expired_c;
  logic                  rsp_err_c;
  logic [MEM_DATA_W-1:0] rsp_rdata_c;

  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != ARB_BUSY),
    .enable  (state_q == ARB_BUSY),
    .expired (timer_expired_c)
  );

  assign grant_c = pick_owner(if_req, ls_req, RR_EN, owner_q);

  // Writes and aborted transactions return zero data.
  assign rsp_err_c   = !mem_drdy;
  assign rsp_rdata_c = (mem_drdy && !((owner_q == OWN_LS) && cmd_q.we)) ? mem_rdata : '0;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    mem_req_d  = mem_req_q;
    if_drdy_d  = 1'b0;
    if_err_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    ls_drdy_d  = 1'b0;
    ls_err_d   = 1'b0;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (if_req || ls_req) begin
          owner_d   = grant_c;
          mem_req_d = 1'b1;
          state_d   = ARB_BUSY;
          if (grant_c == OWN_LS) begin
            cmd_d.we    = ls_we;
            cmd_d.addr  = ls_addr;
            cmd_d.wdata = ls_wdata;
            cmd_d.wstrb = ls_we ? ls_wstrb : '0;
          end else begin
            cmd_d      = '0;
            cmd_d.addr = if_addr;
          end
        end
      end
      ARB_BUSY: begin
        if (mem_drdy || timer_expired_c) begin
          mem_req_d = 1'b0;
          state_d   = ARB_RESP;
          if (owner_q == OWN_LS) begin
            ls_drdy_d  = 1'b1;
            ls_err_d   = rsp_err_c;
            ls_rdata_d = rsp_rdata_c;
          end else begin
            if_drdy_d  = 1'b1;
            if_err_d   = rsp_err_c;
            if_rdata_d = rsp_rdata_c;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_LS;
      cmd_q      <= '0;
      mem_req_q  <= 1'b0;
      if_drdy_q  <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_drdy_q  <= 1'b0;
      ls_err_q   <= 1'b0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cmd_q      <= cmd_d;
      mem_req_q  <= mem_req_d;
      if_drdy_q  <= if_drdy_d;
      if_err_q   <= if_err_d;
      if_rdata_q <= if_rdata_d;
      ls_drdy_q  <= ls_drdy_d;
      ls_err_q   <= ls_err_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_drdy   = if_drdy_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign ls_drdy   = ls_drdy_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_wstrb = cmd_q.wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (TIMEOUT_CYCLES=4); expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_drdy, if_err;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic [3:0]  ls_wstrb = '0;
  logic        ls_drdy, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we, mem_drdy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_drdy(if_drdy), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_drdy(ls_drdy), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_drdy(mem_drdy), .mem_rdata(mem_rdata)
  );

  typedef struct { bit is_ls; bit err; logic [31:0] rdata; } rsp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } cmd_t;
  rsp_t rsp_q[$];
  cmd_t cmd_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Memory model: answers after wait_n BUSY cycles; force_drdy injects stray completions.
  int          wait_n = 0;
  int          wcnt = 0;
  bit          mem_en = 1'b1;
  bit          force_drdy = 1'b0;
  logic [31:0] mem_val = '0;
  assign mem_drdy  = force_drdy | (mem_en && mem_req && (wcnt == wait_n));
  assign mem_rdata = mem_val;
  always @(posedge clk) wcnt <= mem_req ? wcnt + 1 : 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void exp_cmd(bit we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb);
    cmd_q.push_back('{we: we, addr: addr, wdata: wdata, wstrb: wstrb});
  endfunction

  function automatic void exp_rsp(bit is_ls, bit err, logic [31:0] rdata);
    rsp_q.push_back('{is_ls: is_ls, err: err, rdata: rdata});
  endfunction

  // Monitor: checks each new memory command and each requester response against the queues.
  logic mem_req_prev = 1'b0;
  int   busy_run = 0;
  int   last_busy = 0;
  always @(negedge clk) begin
    rsp_t r;
    cmd_t c;
    if (mem_req && !mem_req_prev) begin
      if (cmd_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL mem_grant: unexpected command addr %h, none expected", mem_addr);
      end else begin
        c = cmd_q.pop_front();
        check("mem_we", 32'(mem_we), 32'(c.we));
        check("mem_addr", mem_addr, c.addr);
        check("mem_wstrb", 32'(mem_wstrb), 32'(c.wstrb));
        if (c.we) check("mem_wdata", mem_wdata, c.wdata);
      end
    end
    if (mem_req) busy_run++;
    else begin
      if (mem_req_prev) last_busy = busy_run;
      busy_run = 0;
    end
    mem_req_prev = mem_req;
    if (if_drdy || ls_drdy) begin
      if (rsp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rsp: unexpected drdy if=%0b ls=%0b, none expected", if_drdy, ls_drdy);
      end else begin
        r = rsp_q.pop_front();
        check("rsp_owner_ls", 32'(ls_drdy), 32'(r.is_ls));
        check("rsp_owner_if", 32'(if_drdy), 32'(!r.is_ls));
        if (r.is_ls) begin
          check("ls_err", 32'(ls_err), 32'(r.err));
          check("ls_rdata", ls_rdata, r.rdata);
        end else begin
          check("if_err", 32'(if_err), 32'(r.err));
          check("if_rdata", if_rdata, r.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for `want` drdy pulses; drop_each releases a requester on its own drdy.
  task automatic serve(int want, int budget, bit drop_each);
    int seen = 0;
    int cyc  = 0;
    while (seen < want && cyc < budget) begin
      tick();
      cyc++;
      if (if_drdy || ls_drdy) begin
        seen++;
        if (drop_each) begin
          if (if_drdy) if_req = 1'b0;
          if (ls_drdy) ls_req = 1'b0;
        end
        if (seen == want) begin
          if_req = 1'b0;
          ls_req = 1'b0;
        end
      end
    end
    if (seen < want) begin
      n_checks++; n_fail++;
      $display("FAIL serve_timeout: saw %0d of %0d drdy pulses", seen, want);
      if_req = 1'b0;
      ls_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit exp_ls[4];
    repeat (3) tick();
    check("reset_outputs_zero",
          32'(|{if_drdy, if_rdata, if_err, ls_drdy, ls_rdata, ls_err,
                mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb}), 32'd0);
    rst = 1'b0;
    tick();

    // Zero-wait IF read: one BUSY cycle, drdy two cycles after the request is sampled.
    mem_val = 32'hDEADBEEF; wait_n = 0;
    exp_cmd(1'b0, 32'h100, 32'h0, 4'h0);
    exp_rsp(1'b0, 1'b0, 32'hDEADBEEF);
    if_addr = 32'h100; if_req = 1'b1;
    tick();
    check("t1_mem_req_busy", 32'(mem_req), 32'd1);
    check("t1_no_early_drdy", 32'(if_drdy), 32'd0);
    tick();
    check("t1_if_drdy", 32'(if_drdy), 32'd1);
    check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_mem_req_resp", 32'(mem_req), 32'd0);
    if_req = 1'b0;
    tick(); tick();
    check("t1_busy_len", 32'(last_busy), 32'd1);

    // Tie: LS write goes first, IF read in the following IDLE.
    mem_val = 32'h0F0F0F0F; wait_n = 1;
    exp_cmd(1'b1, 32'h200, 32'hA5A5A5A5, 4'b0011);
    exp_cmd(1'b0, 32'h300, 32'h0, 4'h0);
    exp_rsp(1'b1, 1'b0, 32'h0);
    exp_rsp(1'b0, 1'b0, 32'h0F0F0F0F);
    ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hA5A5A5A5; ls_wstrb = 4'b0011;
    if_addr = 32'h300;
    ls_req = 1'b1; if_req = 1'b1;
    serve(2, 30, 1'b1);
    ls_we = 1'b0;
    tick(); tick();

    // Both requesters held across four grants straight after reset.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("t3_reset_mem_req", 32'(mem_req), 32'd0);
`ifdef MEM_ARB_RR_EN
    exp_ls = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    mem_val = 32'h12345678; wait_n = 0;
    if_addr = 32'h400; ls_addr = 32'h500;
    for (int i = 0; i < 4; i++) begin
      exp_cmd(1'b0, exp_ls[i] ? 32'h500 : 32'h400, 32'h0, 4'h0);
      exp_rsp(exp_ls[i], 1'b0, 32'h12345678);
    end
    if_req = 1'b1; ls_req = 1'b1;
    serve(4, 40, 1'b0);
    tick(); tick();

    // Memory never answers: abort after four BUSY cycles, then IF still works.
    mem_en = 1'b0;
    ls_addr = 32'h600;
    exp_cmd(1'b0, 32'h600, 32'h0, 4'h0);
    exp_rsp(1'b1, 1'b1, 32'h0);
    ls_req = 1'b1;
    serve(1, 20, 1'b1);
    mem_en = 1'b1;
    tick(); tick();
    check("t4_busy_len", 32'(last_busy), 32'd4);
    mem_val = 32'hCAFEF00D; wait_n = 0;
    if_addr = 32'h104;
    exp_cmd(1'b0, 32'h104, 32'h0, 4'h0);
    exp_rsp(1'b0, 1'b0, 32'hCAFEF00D);
    if_req = 1'b1;
    serve(1, 20, 1'b1);
    tick(); tick();

    // Reset on the second BUSY cycle; stray mem_drdy afterwards is ignored.
    mem_val = 32'h55AA55AA; wait_n = 3;
    if_addr = 32'h800;
    exp_cmd(1'b0, 32'h800, 32'h0, 4'h0);
    if_req = 1'b1;
    tick();
    tick();
    rst = 1'b1; if_req = 1'b0;
    tick();
    rst = 1'b0;
    check("t5_mem_req_after_rst", 32'(mem_req), 32'd0);
    check("t5_no_drdy_after_rst", 32'(if_drdy), 32'd0);
    force_drdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stray_drdy_ignored", 32'({if_drdy, ls_drdy, mem_req}), 32'd0);
    end
    force_drdy = 1'b0;
    wait_n = 0;
    if_addr = 32'h804;
    exp_cmd(1'b0, 32'h804, 32'h0, 4'h0);
    exp_rsp(1'b0, 1'b0, 32'h55AA55AA);
    if_req = 1'b1;
    tick();
    check("t5_idle_regrant", 32'(mem_req), 32'd1);
    serve(1, 20, 1'b1);
    tick(); tick();

    // mem_drdy lands on the timeout cycle: completion wins, no error.
    mem_val = 32'h0BADF00D; wait_n = 3;
    ls_addr = 32'h700;
    exp_cmd(1'b0, 32'h700, 32'h0, 4'h0);
    exp_rsp(1'b1, 1'b0, 32'h0BADF00D);
    ls_req = 1'b1;
    serve(1, 20, 1'b1);
    tick(); tick();
    check("t6_busy_len", 32'(last_busy), 32'd4);

    repeat (3) tick();
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
